// File: rtl/gpio_capture_pkg.sv
// Shared constants for the GPIO input capture block: register word indices
// and debounce counter sizing.
package gpio_capture_pkg;

  localparam logic [2:0] LEVEL_LO   = 3'd0;
  localparam logic [2:0] LEVEL_HI   = 3'd1;
  localparam logic [2:0] RISE_EN_LO = 3'd2;
  localparam logic [2:0] RISE_EN_HI = 3'd3;
  localparam logic [2:0] FALL_EN_LO = 3'd4;
  localparam logic [2:0] FALL_EN_HI = 3'd5;
  localparam logic [2:0] STATUS_LO  = 3'd6;
  localparam logic [2:0] STATUS_HI  = 3'd7;

  localparam int DEB_CNT_W  = 2;
  localparam int DEB_THRESH = 3;

endpackage

// File: rtl/gpio_capture_pad.sv
// Per-pad capture slice: sync chain, optional debounce filter (GPIO_CAPTURE_DEBOUNCE_EN),
// filtered level and single-cycle rise/fall edge pulses.
module gpio_capture_pad
  import gpio_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic pad_in,
  input  logic prime,
  input  logic primed,
`ifdef GPIO_CAPTURE_DEBOUNCE_EN
  input  logic tick,
`endif
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   lvl_q, lvl_d;
  logic                   lvl_prev_q, lvl_prev_d;

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_CAPTURE_DEBOUNCE_EN
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

  // Prime bypasses the filter; afterwards a change must survive DEB_THRESH ticks.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (prime) begin
      lvl_d = synced;
      cnt_d = '0;
    end else if (primed && tick) begin
      if (synced != lvl_q) begin
        if (cnt_q == DEB_CNT_W'(DEB_THRESH - 1)) begin
          lvl_d = synced;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  always_comb begin
    lvl_d = (prime || primed) ? synced : lvl_q;
  end
`endif

  // On the prime cycle both level registers load together so no edge is seen.
  assign lvl_prev_d = prime ? synced : lvl_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q     <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pad_in};
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = lvl_q & ~lvl_prev_q;
  assign fall = ~lvl_q & lvl_prev_q;

endmodule

// File: rtl/gpio_input_capture.sv
// GPIO input capture top: prime sequencing, optional debounce prescaler
// (GPIO_CAPTURE_DEBOUNCE_EN), enable/status registers, register bus and irq.
module gpio_input_capture
  import gpio_capture_pkg::*;
#(
  parameter int NPADS       = 44,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_DIV     = 1000
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [NPADS-1:0]  gpio_in,
  input  logic [2:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  input  logic              reg_we,
  input  logic              reg_re,
  output logic [31:0]       reg_rdata,
  output logic              reg_ready,
  output logic              irq
);

  localparam int HIW = NPADS - 32;
  localparam int PW  = $clog2(SYNC_STAGES + 1);

  if (NPADS < 33 || NPADS > 64)        begin : g_bad_npads $error("NPADS out of range"); end
  if (SYNC_STAGES < 2)                 begin : g_bad_sync  $error("SYNC_STAGES below 2"); end
  if (DEB_DIV < 2 || DEB_DIV > 65535)  begin : g_bad_div   $error("DEB_DIV out of range"); end

  logic [PW-1:0]    prime_cnt_q;
  logic             primed_q;
  logic             prime;
  logic [NPADS-1:0] lvl, rise, fall;
  logic [NPADS-1:0] rise_en_q, rise_en_d;
  logic [NPADS-1:0] fall_en_q, fall_en_d;
  logic [NPADS-1:0] status_q, status_d;
  logic [NPADS-1:0] clr;
  logic [63:0]      lvl64, rise64, fall64, stat64;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q;
  logic             irq_q;

  // Down-counter covering the sync chain fill; prime fires once it reaches zero.
  assign prime = !primed_q && (prime_cnt_q == '0);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      prime_cnt_q <= PW'(SYNC_STAGES);
      primed_q    <= 1'b0;
    end else begin
      if (prime_cnt_q != '0) prime_cnt_q <= prime_cnt_q - 1'b1;
      if (prime)             primed_q    <= 1'b1;
    end
  end

`ifdef GPIO_CAPTURE_DEBOUNCE_EN
  logic [15:0] presc_q;
  logic        tick;

  assign tick = (presc_q == 16'd0);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)   presc_q <= 16'(DEB_DIV - 1);
    else if (tick) presc_q <= 16'(DEB_DIV - 1);
    else           presc_q <= presc_q - 16'd1;
  end
`endif

  for (genvar i = 0; i < NPADS; i++) begin : g_pad
    gpio_capture_pad #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_pad (
      .clk    (clk),
      .resetb (resetb),
      .pad_in (gpio_in[i]),
      .prime  (prime),
      .primed (primed_q),
`ifdef GPIO_CAPTURE_DEBOUNCE_EN
      .tick   (tick),
`endif
      .lvl    (lvl[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (reg_we) begin
      case (reg_addr)
        RISE_EN_LO: rise_en_d[31:0]       = reg_wdata;
        RISE_EN_HI: rise_en_d[NPADS-1:32] = reg_wdata[HIW-1:0];
        FALL_EN_LO: fall_en_d[31:0]       = reg_wdata;
        FALL_EN_HI: fall_en_d[NPADS-1:32] = reg_wdata[HIW-1:0];
        STATUS_LO:  clr[31:0]             = reg_wdata;
        STATUS_HI:  clr[NPADS-1:32]       = reg_wdata[HIW-1:0];
        default: ;
      endcase
    end
    // Set is OR'd in after the clear so a same-cycle edge wins over W1C.
    status_d = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  assign lvl64  = 64'(lvl);
  assign rise64 = 64'(rise_en_q);
  assign fall64 = 64'(fall_en_q);
  assign stat64 = 64'(status_q);

  always_comb begin
    rdata_d = rdata_q;
    if (reg_re) begin
      case (reg_addr)
        LEVEL_LO:   rdata_d = lvl64[31:0];
        LEVEL_HI:   rdata_d = lvl64[63:32];
        RISE_EN_LO: rdata_d = rise64[31:0];
        RISE_EN_HI: rdata_d = rise64[63:32];
        FALL_EN_LO: rdata_d = fall64[31:0];
        FALL_EN_HI: rdata_d = fall64[63:32];
        STATUS_LO:  rdata_d = stat64[31:0];
        default:    rdata_d = stat64[63:32];
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      ready_q   <= reg_we | reg_re;
      irq_q     <= |(status_q & (rise_en_q | fall_en_q));
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ready = ready_q;
  assign irq       = irq_q;

endmodule
